yarp_fetch_unit: RTL
====================

Name: yarp_fetch_unit

Overview:
- Decoupled instruction fetch stage for the next-generation yarp core; it replaces the single-cycle fetch path.
- Issues pipelined requests to instruction memory using a req/gnt/rvalid handshake, with a parametrised number of outstanding requests.
- Buffers returned instructions, tagged with their PC, in a prefetch FIFO that feeds decode through a valid/ready interface.
- Supports PC redirect (branch/jump): flushes the buffer and discards in-flight responses.

Parameters:
- RESET_PC, 32'h1000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests (>=1).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- instr_mem_req_o  output  1  fetch request.
- instr_mem_addr_o  output  32  fetch address, word aligned.
- instr_mem_gnt_i  input  1  request accepted this cycle.
- instr_mem_rvalid_i  input  1  response data valid; responses return in order.
- instr_mem_rd_data_i  input  32  response instruction.
- redirect_i  input  1  redirect fetch to redirect_pc_i.
- redirect_pc_i  input  32  new PC, word aligned.
- instr_valid_o  output  1  buffer head valid.
- instr_ready_i  input  1  decode accepts the head.
- instr_o  output  32  head instruction.
- instr_pc_o  output  32  PC of the head instruction.

Behaviour:
- Reset (clk edge with reset=1):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - outstanding=0, discard_cnt=0, FIFO empty.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - instr_mem_addr_o=RESET_PC; instr_mem_req_o is forced to 0 while reset=1.
  - Reset mid-operation abandons all in-flight requests; responses that arrive after reset are not supported by the memory contract.
- Request rule:
  - instr_mem_req_o = !redirect_i && (outstanding < MAX_OUTSTANDING) && (fifo_count + (outstanding - discard_cnt) < FIFO_DEPTH).
  - instr_mem_addr_o = fetch_pc, combinational from the register.
  - A request may drop without a grant. The address stays stable while req is high and ungranted.
- On gnt (with req): fetch_pc += 4 (wraps modulo 2^32); outstanding += 1.
- On rvalid:
  - outstanding -= 1.
  - If discard_cnt > 0: discard_cnt -= 1 and drop the data.
  - Otherwise: push {resp_pc, rd_data} and resp_pc += 4.
  - Simultaneous gnt and rvalid leaves outstanding unchanged.
- Credit check guarantees a push never finds the FIFO full. A push into a full FIFO is an assertion failure.
- Output:
  - First-word-fall-through; instr_valid_o = !fifo_empty.
  - Pop when instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are both honoured.
- Latency: gnt in cycle N, rvalid no earlier than N+1; the entry is visible on instr_valid_o at N+2.
- Redirect (cycle R):
  - req=0 in cycle R; no gnt is legal in R.
  - FIFO flushed (a pop in R is dropped; instr_valid_o=0 at R+1).
  - fetch_pc=resp_pc=redirect_pc_i.
  - discard_cnt = outstanding - rvalid_i (the response in R is dropped too).
  - First new request is presented at R+1.
  - Back-to-back redirects: the last one wins, and discard accounting accumulates correctly.
- The PC is never exposed for a discarded response.

Decomposition:
- yarp_pkg additions:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam YARP_INSTR_BYTES=4
- Sub-module yarp_sync_fifo:
  - Parametrised by type and depth.
  - Ports: push, pop, flush, full, empty, count.
  - Synchronous active-high reset.
  - Reused later for the data path.
- Counters and the request logic stay in yarp_fetch_unit.

Test Plan:
- Reset then single-cycle-gnt memory, rvalid one cycle later, ready=1:
  - Required: addresses 0x1000, 0x1004, 0x1008 issued on consecutive cycles.
  - Required: instr_pc_o matches each address; first instr_valid_o 2 cycles after the first gnt.
- ready=0 with DEPTH=4, MAX_OUTSTANDING=2:
  - Required: exactly 4 grants, then req stays 0; FIFO holds PCs 0x1000–0x100C.
  - Raise ready and pop one: required, one new request at 0x1010.
- Memory withholds gnt for 3 cycles:
  - Required: req held high with addr 0x1000 stable; fetch_pc advances only on the gnt cycle.
- Two requests outstanding, redirect_i=1 with redirect_pc_i=0x2000:
  - Required: next two rvalid responses dropped; instr_valid_o=0 until the first 0x2000 response.
  - Required: instr_pc_o=0x2000.
- Redirect in the same cycle as rvalid and a pop:
  - Required: discard_cnt = outstanding-1, FIFO empty next cycle, req at 0x2000 next cycle.
- fetch_pc=0xFFFFFFFC granted:
  - Required: next address 0x00000000; returned entries carry PCs 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared yarp core types and constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package yarp_pkg;

    localparam int YARP_INSTR_BYTES = 4;

    // One prefetched instruction tagged with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/yarp_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full and pop while empty are ignored; the producer must respect o_full.
module yarp_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  T              i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output T              o_pop_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because r_count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yarp_fetch_unit.sv
// Decoupled instruction fetch: pipelined req/gnt/rvalid requests feeding a PC-tagged prefetch FIFO.
// Latency: gnt in cycle N, rvalid at N+1 earliest, entry visible on instr_valid_o at N+2.
// Backpressure: requests stop once buffered plus live in-flight words would fill the FIFO, or MAX_OUTSTANDING is reached.
module yarp_fetch_unit
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic        instr_mem_gnt_i,
    input  logic        instr_mem_rvalid_i,
    input  logic [31:0] instr_mem_rd_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int          OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int          CW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] INSTR_STEP = 32'(YARP_INSTR_BYTES);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard_cnt;

    logic          w_req;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_credit_ok;
    logic          w_slot_ok;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    // Discarded responses will never land in the FIFO, so only live in-flight words consume credit
    assign w_credit_ok = (int'(w_fifo_count) + int'(r_outstanding) - int'(r_discard_cnt)) < FIFO_DEPTH;
    assign w_slot_ok   = int'(r_outstanding) < MAX_OUTSTANDING;
    assign w_req       = !reset && !redirect_i && w_slot_ok && w_credit_ok;
    assign w_gnt       = w_req && instr_mem_gnt_i;

    assign instr_mem_req_o  = w_req;
    assign instr_mem_addr_o = r_fetch_pc;

    // The response arriving during a redirect belongs to the old stream and is dropped
    assign w_push       = instr_mem_rvalid_i && (r_discard_cnt == '0) && !redirect_i;
    assign w_pop        = instr_valid_o && instr_ready_i;
    assign w_push_entry = '{pc: r_resp_pc, instr: instr_mem_rd_data_i};

    yarp_sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_entry),
        .i_pop      (w_pop),
        .i_flush    (redirect_i),
        .o_pop_dat  (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    // Head is masked to zero when empty so stale storage never leaks a PC
    assign instr_valid_o = !w_fifo_empty;
    assign instr_o       = w_fifo_empty ? 32'h0 : w_head.instr;
    assign instr_pc_o    = w_fifo_empty ? 32'h0 : w_head.pc;

    // PC tracking plus outstanding/discard accounting; a redirect turns every remaining in-flight word into a discard
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
        end else if (redirect_i) begin
            r_fetch_pc    <= redirect_pc_i;
            r_resp_pc     <= redirect_pc_i;
            r_outstanding <= r_outstanding - OW'(instr_mem_rvalid_i);
            r_discard_cnt <= r_outstanding - OW'(instr_mem_rvalid_i);
        end else begin
            if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + INSTR_STEP;
            end
            r_outstanding <= r_outstanding + OW'(w_gnt) - OW'(instr_mem_rvalid_i);
            if (instr_mem_rvalid_i) begin
                if (r_discard_cnt != '0) begin
                    r_discard_cnt <= r_discard_cnt - OW'(1);
                end else begin
                    r_resp_pc <= r_resp_pc + INSTR_STEP;
                end
            end
        end
    end

    // The credit check must always leave room for an accepted response
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && w_fifo_full));
        end
    end

endmodule
